// File: rtl/keyboard_controller.sv
// keyboard_controller
//   Receives PS/2 keyboard frames and decodes arrow-key and W/A/S/D make/break
//   codes into four held movement levels for the player update stage.
//
// Ports
//   clock          system clock, all logic on posedge
//   reset          asynchronous, active-low reset
//   ps2_clk        raw PS/2 clock from the keyboard (asynchronous)
//   ps2_dat        raw PS/2 data from the keyboard (asynchronous)
//   turn_right     Right arrow or D held
//   turn_left      Left arrow or A held
//   move_forward   Up arrow or W held
//   move_backward  Down arrow or S held
//   rx_byte        last correctly received byte
//   byte_valid     one-cycle pulse when rx_byte is updated
//   frame_error    one-cycle pulse on parity, stop-bit or timeout failure
module keyboard_controller #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // Held-key bit positions, shared by the arrow and letter vectors
  localparam int K_RIGHT = 0;
  localparam int K_LEFT  = 1;
  localparam int K_FWD   = 2;
  localparam int K_BACK  = 3;

  logic             clk_s1, clk_s2, clk_prev;
  logic             dat_s1, dat_s2;
  logic             fall;
  logic [1:0]       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             parity_bit;
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout;
  logic [3:0]       held_arrow;
  logic [3:0]       held_letter;
  logic             ext, brk;

  // Synchronizers reset high so that releasing reset never looks like a
  // falling PS/2 clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // The idle counter has reached its last value and no edge arrives this
  // cycle, so it would reach TIMEOUT_CYCLES now.
  assign timeout = (state != IDLE) && !fall && (idle_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      parity_bit  <= 1'b0;
      idle_cnt    <= '0;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (state == IDLE || fall) begin
        idle_cnt <= '0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fall && !dat_s2) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (fall) begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            parity_bit <= dat_s2;
            state      <= STOP;
          end
        end
        default: begin
          if (fall) begin
            // Odd parity over data plus parity bit, and stop bit must be 1
            if (dat_s2 && (^{shift, parity_bit})) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
          end
        end
      endcase

      if (timeout) begin
        state       <= IDLE;
        frame_error <= 1'b1;
      end
    end
  end

  // Scan-code decoder: E0/F0 are sticky prefixes consumed by the next byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_arrow  <= 4'b0000;
      held_letter <= 4'b0000;
      ext         <= 1'b0;
      brk         <= 1'b0;
    end else if (frame_error) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      case (rx_byte)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'h00, 8'hFF: begin
          held_arrow  <= 4'b0000;
          held_letter <= 4'b0000;
          ext         <= 1'b0;
          brk         <= 1'b0;
        end
        default: begin
          if (ext) begin
            case (rx_byte)
              8'h74:   held_arrow[K_RIGHT] <= !brk;
              8'h6B:   held_arrow[K_LEFT]  <= !brk;
              8'h75:   held_arrow[K_FWD]   <= !brk;
              8'h72:   held_arrow[K_BACK]  <= !brk;
              default: ;
            endcase
          end else begin
            case (rx_byte)
              8'h23:   held_letter[K_RIGHT] <= !brk;
              8'h1C:   held_letter[K_LEFT]  <= !brk;
              8'h1D:   held_letter[K_FWD]   <= !brk;
              8'h1B:   held_letter[K_BACK]  <= !brk;
              default: ;
            endcase
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

  assign turn_right    = held_arrow[K_RIGHT] | held_letter[K_RIGHT];
  assign turn_left     = held_arrow[K_LEFT]  | held_letter[K_LEFT];
  assign move_forward  = held_arrow[K_FWD]   | held_letter[K_FWD];
  assign move_backward = held_arrow[K_BACK]  | held_letter[K_BACK];

endmodule
